// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues word requests to imem, buffers responses in an in-order FIFO for decode.
// Response to IF_vld takes 1 cycle; issue stalls when FIFO + in-flight credit is used up; head holds while !ID_rdy.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_vld,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_rdy,
    input  logic        imem_rsp_vld,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] IF_pc,
    output logic [31:0] IF_inst,
    output logic        IF_vld,
    input  logic        ID_rdy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW+1:0] DEPTH_L = (CW+2)'(FIFO_DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   fifo_pc   [FIFO_DEPTH];
    logic [31:0]   fifo_inst [FIFO_DEPTH];
    logic [31:0]   pcq       [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, pcq_rd, pcq_wr;
    logic [CW-1:0] fifo_cnt, out_cnt, drop_cnt;
    logic [CW+1:0] used;
    logic          req_fire, rsp_keep, pop;

    // Credit covers buffered entries plus every request whose response is still owed.
    assign used          = (CW+2)'(fifo_cnt) + (CW+2)'(out_cnt) + (CW+2)'(drop_cnt);
    assign imem_req_vld  = rst_n && !redirect && (used < DEPTH_L);
    assign imem_req_addr = fetch_pc;

    assign req_fire = imem_req_vld && imem_req_rdy;
    assign rsp_keep = rst_n && !redirect && imem_rsp_vld && (drop_cnt == '0);
    assign pop      = IF_vld && ID_rdy;

    assign IF_vld  = (fifo_cnt != '0);
    assign IF_pc   = IF_vld ? fifo_pc[rd_ptr]   : 32'h0;
    assign IF_inst = IF_vld ? fifo_inst[rd_ptr] : 32'h0;

    always_ff @(posedge clk) begin
        if (req_fire) begin
            pcq[pcq_wr] <= fetch_pc;
        end
        if (rsp_keep) begin
            fifo_pc[wr_ptr]   <= pcq[pcq_rd];
            fifo_inst[wr_ptr] <= imem_rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            pcq_rd   <= '0;
            pcq_wr   <= '0;
            fifo_cnt <= '0;
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else if (redirect) begin
            // Everything still owed by memory becomes stale; a response landing now is one of them.
            fetch_pc <= redirect_pc & ~32'h3;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            pcq_rd   <= '0;
            pcq_wr   <= '0;
            fifo_cnt <= '0;
            out_cnt  <= '0;
            drop_cnt <= drop_cnt + out_cnt - CW'(imem_rsp_vld);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
                pcq_wr   <= pcq_wr + AW'(1);
            end
            if (imem_rsp_vld && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            if (rsp_keep) begin
                wr_ptr <= wr_ptr + AW'(1);
                pcq_rd <= pcq_rd + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            out_cnt  <= out_cnt + CW'(req_fire) - CW'(rsp_keep);
            fifo_cnt <= fifo_cnt + CW'(rsp_keep) - CW'(pop);
        end
    end

    // A response with nothing outstanding means memory broke the in-order contract.
    assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_vld |-> ((out_cnt != '0) || (drop_cnt != '0)));

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Instruction fetch stage of the RV32 core. It owns the fetch PC and issues word requests to instruction memory over a valid/ready request and valid-only response channel. Returned instructions are buffered in a small in-order prefetch FIFO that feeds InstDecode through a valid/ready handshake. A redirect from Execute (branch, jump or trap) squashes the FIFO and all in-flight fetches, then restarts fetch at the new PC.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset; bits [1:0] must be 0.
FIFO_DEPTH, 2, prefetch FIFO entries; also the maximum number of in-flight requests (power of 2, ≥2).

Ports:
clk  input  1  core clock; all state updates on rising edge.
rst_n  input  1  synchronous reset, active-low.
imem_req_vld  output  1  request valid.
imem_req_addr  output  32  word-aligned fetch address.
imem_req_rdy  input  1  memory accepts request; handshake when vld&&rdy.
imem_rsp_vld  input  1  response valid; responses return in request order, latency ≥1 cycle.
imem_rsp_data  input  32  instruction word.
redirect  input  1  flush and restart fetch.
redirect_pc  input  32  new fetch PC; bits [1:0] are ignored and treated as 0.
IF_pc  output  32  PC of the head instruction.
IF_inst  output  32  head instruction word.
IF_vld  output  1  head valid (FIFO not empty).
ID_rdy  input  1  decode consumes head when IF_vld&&ID_rdy.

Behaviour:
- State: fetch_pc; FIFO of {pc, inst}; out_cnt (live in-flight requests); drop_cnt (stale in-flight requests); pc queue recording the address of each live request.
- Reset (rst_n=0 at clk edge): fetch_pc=RESET_PC; FIFO empty; out_cnt=drop_cnt=0; imem_req_vld=0; IF_vld=0; IF_pc=0; IF_inst=0.
- Issue: imem_req_vld=1 iff !redirect && (fifo_cnt+out_cnt+drop_cnt) < FIFO_DEPTH. imem_req_addr=fetch_pc. On handshake: fetch_pc += 4 (wraps modulo 2^32), out_cnt++, and the address is pushed to the pc queue.
- Hold: while imem_req_vld=1 and imem_req_rdy=0, imem_req_addr stays stable.
- Response with drop_cnt>0: discarded; drop_cnt--.
- Response with drop_cnt=0: {pc-queue head, imem_rsp_data} is written to the FIFO; out_cnt--. Credit accounting guarantees the FIFO is never full at that point; a response with out_cnt=drop_cnt=0 is a protocol error (assertion).
- Output: IF_vld = FIFO non-empty. IF_pc/IF_inst show the head entry and are stable while IF_vld&&!ID_rdy. Minimum latency from response to IF_vld is 1 cycle (registered FIFO write).
- Push and pop in the same cycle are both honoured; the FIFO count is unchanged.
- Redirect (takes priority over all else that cycle):
  - fetch_pc = {redirect_pc[31:2], 2'b00}; FIFO cleared (IF_vld=0 next cycle, even if ID_rdy popped this cycle).
  - drop_cnt = drop_cnt + out_cnt − (imem_rsp_vld ? 1 : 0); out_cnt=0; pc queue cleared.
  - A response arriving in the redirect cycle is always discarded.
  - No request is issued in the redirect cycle. The first request at the new PC is issued the next cycle, if credit allows.
- Back-to-back redirects: the last one wins; drops keep accumulating.
- Reset asserted mid-transfer: all counters clear. Memory responses after reset are out of scope (the memory is reset together with the core).
- Throughput: 1 instruction/cycle sustained when memory latency ≤ FIFO_DEPTH−1 and ID_rdy=1.

Test Plan:
- Reset with RESET_PC=0x0000_0000, 1-cycle memory, ID_rdy=1: requests go to 0x0,0x4,0x8,…; IF_pc sequence is 0x0,0x4,0x8 with matching IF_inst; 1 instruction/cycle after fill.
- ID_rdy=0 for 10 cycles: exactly FIFO_DEPTH (2) instructions are buffered; imem_req_vld drops to 0; IF_pc/IF_inst are stable. On ID_rdy=1, drain in order with no loss.
- imem_req_rdy=0 for 3 cycles at addr 0x10: imem_req_addr holds 0x10; no duplicate or skipped PC once accepted.
- Redirect to 0x0000_0103 with 2 in-flight requests (3-cycle memory): both stale responses are discarded; first IF_pc after redirect is 0x0000_0100; no stale instruction reaches decode.
- Redirect in the same cycle as a response and a decode pop: response dropped; FIFO empty next cycle; refetch starts at redirect_pc the following cycle.
- fetch_pc=0xFFFF_FFFC continuous fetch: next request address wraps to 0x0000_0000; rst_n=0 mid-stream clears IF_vld and restarts at RESET_PC.
